// File: rtl/eth_sched_pkg.sv
// Shared types and defaults for the Ethernet FIFO read-side scheduler.
package eth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam int LEN_W        = 16;
    localparam int DEF_MAX_LEN  = 1024;
    localparam int DEF_IDLE_TO  = 256;
    localparam int DEF_GAP_CYC  = 12;
    localparam int DEF_RD_LAT   = 2;
    localparam int DEF_SKID_DEP = 4;

    // Bits needed to hold 0..maxVal, never less than one.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sched_skid_fifo.sv
// Small register FIFO that absorbs bytes already requested from the upstream FIFO.
module sched_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full buffer is only accepted when a pop frees a slot the same cycle.
    assign w_doPop  = i_pop & (r_count != '0);
    assign w_doPush = i_push & ((r_count != CNT_W'(DEPTH)) | w_doPop);

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/eth_fifo_rd_sched.sv
// Reads bytes out of the async FIFO and re-emits them as length-limited,
// idle-terminated valid/ready frames with an inter-frame gap.
module eth_fifo_rd_sched
    import eth_sched_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int IDLE_TO  = DEF_IDLE_TO,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int SKID_DEP = DEF_SKID_DEP
) (
    input  logic             i_rd_clk,
    input  logic             i_rd_rst,
    input  logic             i_enable,
    input  logic             i_rd_empty,
    output logic             o_rd_en,
    input  logic [7:0]       i_rd_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_last,
    output logic [LEN_W-1:0] o_tx_len,
    output logic             o_busy
);

    localparam int OCC_W    = $clog2(SKID_DEP + 1);
    localparam int SUM_W    = OCC_W + 1;
    localparam int IDLE_W   = cntWidth(IDLE_TO);
    localparam int GAP_W    = cntWidth(GAP_CYC);
    localparam int GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 1 : 0;

    sched_state_t     r_state;
    sched_state_t     w_nextState;
    logic [LEN_W-1:0] r_rdCnt;
    logic [LEN_W-1:0] r_outCnt;
    logic [LEN_W-1:0] r_lenHold;
    logic [IDLE_W-1:0] r_idleCnt;
    logic [GAP_W-1:0] r_gapCnt;
    logic             r_term;
    logic [RD_LAT-1:0] r_vldPipe;

    logic [OCC_W-1:0] w_skidCount;
    logic [7:0]       w_skidHead;
    logic [SUM_W-1:0] w_inFlight;
    logic [SUM_W-1:0] w_used;
    logic             w_rdEn;
    logic             w_push;
    logic             w_valid;
    logic             w_last;
    logic             w_hs;
    logic             w_termHit;

    sched_skid_fifo #(
        .DEPTH (SKID_DEP),
        .W     (8)
    ) u_skid (
        .i_clk   (i_rd_clk),
        .i_rst   (i_rd_rst),
        .i_push  (w_push),
        .i_data  (i_rd_data),
        .i_pop   (w_hs),
        .o_data  (w_skidHead),
        .o_count (w_skidCount)
    );

    always_comb begin
        w_inFlight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_inFlight = w_inFlight + SUM_W'(r_vldPipe[k]);
        end
    end

    // Reading only while buffered plus requested bytes leave a free slot means
    // every returning byte always has room in the skid buffer.
    assign w_used  = SUM_W'(w_skidCount) + w_inFlight;
    assign w_rdEn  = (r_state == BURST) & ~i_rd_empty & (w_used < SUM_W'(SKID_DEP))
                   & (r_rdCnt < LEN_W'(MAX_LEN));
    assign w_push  = r_vldPipe[RD_LAT-1];

    // The lone buffered byte is held back until the frame is known to be closing,
    // so the genuine final byte is the one that carries tx_last.
    assign w_valid = (w_skidCount >= OCC_W'(2)) | (r_term & (w_skidCount != '0));
    assign w_last  = r_term & (w_skidCount == OCC_W'(1)) & (w_inFlight == '0);
    assign w_hs    = w_valid & i_tx_ready;

    always_comb begin
        w_nextState = r_state;
        w_termHit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable & ~i_rd_empty) begin
                    w_nextState = BURST;
                end
            end
            BURST: begin
                w_termHit = (r_rdCnt == LEN_W'(MAX_LEN))
                          | (i_rd_empty & (r_idleCnt == IDLE_W'(IDLE_TO - 1)));
                if (w_termHit) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs & w_last) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == GAP_W'(GAP_LAST)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_rd_clk) begin
        if (i_rd_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_rd_clk) begin
        if (i_rd_rst) begin
            r_rdCnt   <= '0;
            r_outCnt  <= '0;
            r_lenHold <= '0;
            r_idleCnt <= '0;
            r_gapCnt  <= '0;
            r_term    <= 1'b0;
            r_vldPipe <= '0;
        end else begin
            r_vldPipe[0] <= w_rdEn;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vldPipe[k] <= r_vldPipe[k-1];
            end

            if ((r_state == IDLE) && (w_nextState == BURST)) begin
                r_rdCnt   <= '0;
                r_outCnt  <= '0;
                r_idleCnt <= '0;
                r_term    <= 1'b0;
            end else begin
                if (w_rdEn) begin
                    r_rdCnt   <= r_rdCnt + 1'b1;
                    r_idleCnt <= '0;
                end else if ((r_state == BURST) && i_rd_empty
                             && (r_idleCnt != IDLE_W'(IDLE_TO))) begin
                    r_idleCnt <= r_idleCnt + 1'b1;
                end
                if (w_termHit) begin
                    r_term <= 1'b1;
                end
                if (w_hs && (r_outCnt != '1)) begin
                    r_outCnt <= r_outCnt + 1'b1;
                end
            end

            if (w_hs & w_last) begin
                r_lenHold <= r_outCnt + 1'b1;
            end

            if (r_state != GAP) begin
                r_gapCnt <= '0;
            end else if (r_gapCnt != GAP_W'(GAP_LAST)) begin
                r_gapCnt <= r_gapCnt + 1'b1;
            end
        end
    end

    assign o_rd_en    = w_rdEn;
    assign o_tx_valid = w_valid;
    assign o_tx_data  = w_valid ? w_skidHead : 8'h00;
    assign o_tx_last  = w_last;
    assign o_tx_len   = w_last ? (r_outCnt + 1'b1) : r_lenHold;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_eth_fifo_rd_sched.sv
// Self-checking bench: a byte-queue FIFO model feeds the scheduler and every
// output handshake is compared against the queue of bytes read and expected frame lengths.
module tb_eth_fifo_rd_sched;
    import eth_sched_pkg::*;

    localparam int MAX_LEN  = 1024;
    localparam int IDLE_TO  = 256;
    localparam int GAP_CYC  = 12;
    localparam int RD_LAT   = 2;
    localparam int SKID_DEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rdEmpty = 1'b1;
    logic        rdEn;
    logic [7:0]  rdData = 8'h00;
    logic        txValid;
    logic        txReady = 1'b0;
    logic [7:0]  txData;
    logic        txLast;
    logic [15:0] txLen;
    logic        busy;

    eth_fifo_rd_sched #(
        .MAX_LEN  (MAX_LEN),
        .IDLE_TO  (IDLE_TO),
        .GAP_CYC  (GAP_CYC),
        .RD_LAT   (RD_LAT),
        .SKID_DEP (SKID_DEP)
    ) dut (
        .i_rd_clk   (clk),
        .i_rd_rst   (rst),
        .i_enable   (enable),
        .i_rd_empty (rdEmpty),
        .o_rd_en    (rdEn),
        .i_rd_data  (rdData),
        .o_tx_valid (txValid),
        .i_tx_ready (txReady),
        .o_tx_data  (txData),
        .o_tx_last  (txLast),
        .o_tx_len   (txLen),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nA;
        int pause;
        int nB;
        int len0;
        int len1;
        int len2;
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  fifoQ [$];
    logic [7:0]  dlyQ [$];
    logic [7:0]  expQ [$];
    int          expLen [$];

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   frameCnt = 0;
    int   nextByte = 0;
    int   lastRdCycle = 0;
    int   lastHsCycle = 0;
    bit   drvRst = 1'b1;
    bit   drvEnable = 1'b0;
    bit   drvReady = 1'b0;
    bit   randReady = 1'b0;
    bit   timingChecks = 1'b0;
    bit   occChecks = 1'b0;
    bit   gapBusyPending = 1'b0;
    bit   gapRdPending = 1'b0;
    bit   stallPending = 1'b0;
    logic [7:0] stallData = 8'h00;
    logic stallLast = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic pushBytes(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                fifoQ.push_back(8'($urandom_range(0, 255)));
            end else begin
                fifoQ.push_back(8'(nextByte));
                nextByte++;
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then sample and score.
    task automatic applyStimulus();
        logic [7:0] b;
        bit         expLast;
        @(negedge clk);
        cycle++;
        rst     = drvRst;
        enable  = drvEnable;
        txReady = randReady ? ($urandom_range(0, 2) == 0) : drvReady;
        rdData  = dlyQ.pop_front();
        rdEmpty = (fifoQ.size() == 0);
        #1;
        if (!rst && gapBusyPending && !busy) begin
            checkOutput("gap_length", cycle - lastHsCycle, GAP_CYC + 1);
            gapBusyPending = 1'b0;
        end
        if (!rst && gapRdPending && rdEn) begin
            checkOutput("gap_to_next_read", cycle - lastHsCycle, GAP_CYC + 2);
            gapRdPending = 1'b0;
        end
        if (rdEn) begin
            checkOutput("rd_en_vs_empty", int'(fifoQ.size() > 0), 1);
            if (fifoQ.size() > 0) begin
                b = fifoQ.pop_front();
                expQ.push_back(b);
                dlyQ.push_back(b);
            end else begin
                dlyQ.push_back(8'h00);
            end
            lastRdCycle = cycle;
        end else begin
            dlyQ.push_back(8'h00);
        end
        if (rst) begin
            stallPending = 1'b0;
        end else begin
            if (occChecks) begin
                checkOutput("skid_occupancy_bound", int'(int'(dut.w_skidCount) <= SKID_DEP), 1);
            end
            if (stallPending) begin
                checkOutput("stall_valid", int'(txValid), 1);
                checkOutput("stall_data", int'(txData), int'(stallData));
                checkOutput("stall_last", int'(txLast), int'(stallLast));
            end
            stallPending = txValid & ~txReady;
            stallData    = txData;
            stallLast    = txLast;
            if (txValid && txReady) begin
                checkOutput("unexpected_byte", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    checkOutput("tx_data", int'(txData), int'(expQ.pop_front()));
                end
                frameCnt++;
                expLast = (expLen.size() > 0) && (frameCnt == expLen[0]);
                checkOutput("tx_last", int'(txLast), int'(expLast));
                if (expLast) begin
                    checkOutput("tx_len", int'(txLen), expLen[0]);
                    if (timingChecks) begin
                        if (expLen[0] < MAX_LEN) begin
                            checkOutput("timeout_close", cycle - lastRdCycle, IDLE_TO + 1);
                        end
                        gapBusyPending = 1'b1;
                        gapRdPending   = (fifoQ.size() > 0);
                    end
                    void'(expLen.pop_front());
                    frameCnt    = 0;
                    lastHsCycle = cycle;
                end
            end
        end
    endtask

    task automatic runWhileQueued(input int budget, input string name);
        int n = 0;
        while (fifoQ.size() > 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({name, "_drain_budget"}, int'(n < budget), 1);
    endtask

    task automatic runUntilDone(input int budget, input string name);
        int n = 0;
        while ((expLen.size() > 0 || fifoQ.size() > 0 || busy) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({name, "_done_budget"}, int'(n < budget), 1);
    endtask

    initial begin
        int n;
        int rdCount;
        int busyCount;

        vecs[0] = '{nA: 10,          pause: 0,           nB: 0, len0: 10,      len1: 0,       len2: 0};
        vecs[1] = '{nA: 2500,        pause: 0,           nB: 0, len0: 1024,    len1: 1024,    len2: 452};
        vecs[2] = '{nA: 5,           pause: IDLE_TO - 2, nB: 5, len0: 10,      len1: 0,       len2: 0};
        vecs[3] = '{nA: 5,           pause: IDLE_TO + 5, nB: 5, len0: 5,       len1: 5,       len2: 0};
        vecs[4] = '{nA: MAX_LEN,     pause: 0,           nB: 0, len0: MAX_LEN, len1: 0,       len2: 0};
        vecs[5] = '{nA: MAX_LEN + 1, pause: 0,           nB: 0, len0: MAX_LEN, len1: 1,       len2: 0};

        for (int i = 0; i < RD_LAT; i++) begin
            dlyQ.push_back(8'h00);
        end

        // Reset state
        repeat (3) applyStimulus();
        drvRst = 1'b0;
        applyStimulus();
        checkOutput("reset_rd_en", int'(rdEn), 0);
        checkOutput("reset_tx_valid", int'(txValid), 0);
        checkOutput("reset_tx_data", int'(txData), 0);
        checkOutput("reset_tx_last", int'(txLast), 0);
        checkOutput("reset_tx_len", int'(txLen), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // Table-driven frames with tx_ready held high
        drvReady     = 1'b1;
        drvEnable    = 1'b1;
        timingChecks = 1'b1;
        for (int r = 0; r < 6; r++) begin
            $display("[TB] vector %0d: %0d bytes, pause %0d, %0d bytes", r, vecs[r].nA, vecs[r].pause, vecs[r].nB);
            if (vecs[r].len0 > 0) expLen.push_back(vecs[r].len0);
            if (vecs[r].len1 > 0) expLen.push_back(vecs[r].len1);
            if (vecs[r].len2 > 0) expLen.push_back(vecs[r].len2);
            pushBytes(vecs[r].nA, 1'b0);
            runWhileQueued(20000, "vector");
            repeat (vecs[r].pause) applyStimulus();
            pushBytes(vecs[r].nB, 1'b0);
            runUntilDone(20000, "vector");
        end
        timingChecks   = 1'b0;
        gapBusyPending = 1'b0;
        gapRdPending   = 1'b0;

        // Random backpressure over a 300-byte frame
        $display("[TB] random tx_ready over a 300-byte frame");
        occChecks = 1'b1;
        randReady = 1'b1;
        expLen.push_back(300);
        pushBytes(300, 1'b1);
        runUntilDone(10000, "random_ready");
        randReady = 1'b0;
        occChecks = 1'b0;

        // Reset mid-frame after 37 output bytes
        $display("[TB] reset mid-frame");
        expLen.push_back(100);
        pushBytes(100, 1'b1);
        n = 0;
        while (frameCnt < 37 && n < 2000) begin
            applyStimulus();
            n++;
        end
        checkOutput("reset_frame_budget", int'(n < 2000), 1);
        drvRst   = 1'b1;
        drvReady = 1'b0;
        applyStimulus();
        drvRst   = 1'b0;
        drvReady = 1'b1;
        expQ.delete();
        expLen.delete();
        frameCnt = 0;
        applyStimulus();
        checkOutput("midreset_rd_en", int'(rdEn), 0);
        checkOutput("midreset_tx_valid", int'(txValid), 0);
        checkOutput("midreset_tx_data", int'(txData), 0);
        checkOutput("midreset_tx_last", int'(txLast), 0);
        checkOutput("midreset_tx_len", int'(txLen), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        expLen.push_back(fifoQ.size());
        runUntilDone(5000, "after_reset");

        // Drop enable mid-frame
        $display("[TB] enable dropped mid-frame");
        expLen.push_back(50);
        pushBytes(50, 1'b0);
        n = 0;
        while (frameCnt < 10 && n < 2000) begin
            applyStimulus();
            n++;
        end
        checkOutput("enable_frame_budget", int'(n < 2000), 1);
        drvEnable = 1'b0;
        runUntilDone(5000, "enable_drop");
        pushBytes(20, 1'b0);
        rdCount   = 0;
        busyCount = 0;
        repeat (300) begin
            applyStimulus();
            rdCount   += int'(rdEn);
            busyCount += int'(busy);
        end
        checkOutput("disabled_rd_en_count", rdCount, 0);
        checkOutput("disabled_busy_count", busyCount, 0);
        drvEnable = 1'b1;
        expLen.push_back(20);
        runUntilDone(5000, "reenable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
